// File: rtl/sd_dat_rx_crc_chk.sv
// rtl/sd_dat_rx_crc_chk.sv - SD DAT0 block receiver with CRC16 check; optional start-bit timeout via SD_RX_TIMEOUT_EN
module sd_dat_rx_crc_chk #(
    parameter int BLK_BYTES = 512,
    parameter int TO_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic        ARM,
    input  logic        DAT_IN,
    output logic [7:0]  BYTE_OUT,
    output logic        BYTE_VLD,
    output logic        BUSY,
    output logic        DONE,
    output logic        CRC_OK,
    output logic        CRC_ERR,
    output logic        END_ERR,
    output logic        TO_ERR,
    output logic [15:0] CRC_CALC
);

    localparam int CW = $clog2(BLK_BYTES * 8) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(BLK_BYTES * 8 - 1);
    localparam logic [CW-1:0] LAST_CRC = CW'(15);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_DATA,
        S_CRC,
        S_END
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0] bit_cnt;
    logic [6:0]    shreg;
    logic [15:0]   crc;
    logic [15:0]   rx_crc;
    logic [7:0]    byte_out;
    logic          byte_vld;
    logic          done;
    logic          crc_ok;
    logic          crc_err;
    logic          end_err;

`ifdef SD_RX_TIMEOUT_EN
    localparam int TW = $clog2(TO_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_CYCLES - 1);
    logic [TW-1:0] to_cnt;
    logic          to_err;
`else
    logic unused_to;
    assign unused_to = (TO_CYCLES != 0);
`endif

    // CCITT CRC16 step: x^16 + x^12 + x^5 + 1, one data bit per call
    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic d);
        logic        inv;
        logic [15:0] n;
        inv   = d ^ c[15];
        n     = {c[14:0], inv};
        n[5]  = n[5] ^ inv;
        n[12] = n[12] ^ inv;
        return n;
    endfunction

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ARM is accepted without EN, everything else waits for EN
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ARM) state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (EN) begin
                    if (!DAT_IN) begin
                        state_nxt = S_DATA;
                    end
`ifdef SD_RX_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        state_nxt = S_IDLE;
                    end
`endif
                end
            end
            S_DATA: begin
                if (EN && bit_cnt == LAST_BIT) state_nxt = S_CRC;
            end
            S_CRC: begin
                if (EN && bit_cnt == LAST_CRC) state_nxt = S_END;
            end
            S_END: begin
                if (EN) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: byte assembly, CRC accumulation, received CRC capture and result flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            crc      <= '0;
            rx_crc   <= '0;
            byte_out <= '0;
            byte_vld <= 1'b0;
            done     <= 1'b0;
            crc_ok   <= 1'b0;
            crc_err  <= 1'b0;
            end_err  <= 1'b0;
`ifdef SD_RX_TIMEOUT_EN
            to_cnt   <= '0;
            to_err   <= 1'b0;
`endif
        end else begin
            byte_vld <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ARM) begin
                        bit_cnt <= '0;
                        crc     <= '0;
                        rx_crc  <= '0;
                        crc_ok  <= 1'b0;
                        crc_err <= 1'b0;
                        end_err <= 1'b0;
`ifdef SD_RX_TIMEOUT_EN
                        to_cnt  <= '0;
                        to_err  <= 1'b0;
`endif
                    end
                end
                S_WAIT_START: begin
                    if (EN) begin
                        if (!DAT_IN) begin
                            bit_cnt <= '0;
                        end
`ifdef SD_RX_TIMEOUT_EN
                        else if (to_cnt == TO_LAST) begin
                            done   <= 1'b0 | 1'b1;
                            to_err <= 1'b1;
                            crc_ok <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
`endif
                    end
                end
                S_DATA: begin
                    if (EN) begin
                        shreg <= {shreg[5:0], DAT_IN};
                        crc   <= crc_next(crc, DAT_IN);
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                        if (bit_cnt[2:0] == 3'd7) begin
                            byte_out <= {shreg, DAT_IN};
                            byte_vld <= 1'b1;
                        end
                    end
                end
                S_CRC: begin
                    if (EN) begin
                        rx_crc  <= {rx_crc[14:0], DAT_IN};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                S_END: begin
                    if (EN) begin
                        done    <= 1'b1;
                        crc_err <= (rx_crc != crc);
                        end_err <= ~DAT_IN;
                        crc_ok  <= (rx_crc == crc) & DAT_IN;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BYTE_OUT = byte_out;
    assign BYTE_VLD = byte_vld;
    assign BUSY     = (state != S_IDLE);
    assign DONE     = done;
    assign CRC_OK   = crc_ok;
    assign CRC_ERR  = crc_err;
    assign END_ERR  = end_err;
    assign CRC_CALC = crc;
`ifdef SD_RX_TIMEOUT_EN
    assign TO_ERR   = to_err;
`else
    assign TO_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_sd_dat_rx_crc_chk.sv
// tb/tb_sd_dat_rx_crc_chk.sv - directed bench for sd_dat_rx_crc_chk
module tb_sd_dat_rx_crc_chk;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic        ARM;
    logic        DAT_IN;
    logic [7:0]  BYTE_OUT;
    logic        BYTE_VLD;
    logic        BUSY;
    logic        DONE;
    logic        CRC_OK;
    logic        CRC_ERR;
    logic        END_ERR;
    logic        TO_ERR;
    logic [15:0] CRC_CALC;

    int vectors     = 0;
    int miscompares = 0;
    int byte_cnt    = 0;
    int bad_byte    = 0;
    int done_cnt    = 0;
    int gap_max     = 0;
    logic arm_mid   = 1'b0;

    sd_dat_rx_crc_chk #(.BLK_BYTES(512), .TO_CYCLES(100)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .ARM(ARM), .DAT_IN(DAT_IN),
        .BYTE_OUT(BYTE_OUT), .BYTE_VLD(BYTE_VLD), .BUSY(BUSY), .DONE(DONE),
        .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR), .END_ERR(END_ERR), .TO_ERR(TO_ERR),
        .CRC_CALC(CRC_CALC)
    );

    always #5 CLK = ~CLK;

    // Byte and DONE pulse monitor, sampled on the inactive edge
    always @(negedge CLK) begin
        if (BYTE_VLD) begin
            byte_cnt++;
            if (BYTE_OUT !== 8'hFF) bad_byte++;
        end
        if (DONE) done_cnt++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send_bit(input logic b);
        DAT_IN = b;
        EN = 1'b1;
        tick();
        EN = 1'b0;
        if (gap_max > 0) repeat (2 + $urandom_range(0, gap_max)) tick();
    endtask

    task automatic arm_pulse(input logic en_val, input logic d);
        ARM = 1'b1;
        EN = en_val;
        DAT_IN = d;
        tick();
        ARM = 1'b0;
        EN = 1'b0;
        DAT_IN = 1'b1;
    endtask

    task automatic send_block(input logic [15:0] crc_val, input logic end_bit, input int abort_at);
        repeat (3) send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 512; i++) begin
            if (i == abort_at) return;
            if (arm_mid && i == 256) begin
                ARM = 1'b1;
                tick();
                ARM = 1'b0;
            end
            repeat (8) send_bit(1'b1);
        end
        for (int k = 15; k >= 0; k--) send_bit(crc_val[k]);
        send_bit(end_bit);
    endtask

    task automatic test_reset();
        RST = 1'b1; EN = 1'b0; ARM = 1'b0; DAT_IN = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        vectors++;
        if ({BUSY, DONE, CRC_OK, CRC_ERR, END_ERR, TO_ERR, BYTE_VLD} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 0000000", {BUSY, DONE, CRC_OK, CRC_ERR, END_ERR, TO_ERR, BYTE_VLD});
        end
        vectors++;
        if ({BYTE_OUT, CRC_CALC} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h expected 000000", {BYTE_OUT, CRC_CALC});
        end
    endtask

    task automatic test_good_block();
        int b0, bb0, d0;
        b0 = byte_cnt; bb0 = bad_byte; d0 = done_cnt;
        arm_pulse(1'b1, 1'b0);
        vectors++;
        if (BUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL good_busy: got %b expected 1", BUSY);
        end
        send_block(16'h7FA1, 1'b1, -1);
        repeat (2) tick();
        vectors++;
        if (byte_cnt - b0 !== 512) begin
            miscompares++;
            $display("FAIL good_bytes: got %0d expected 512", byte_cnt - b0);
        end
        vectors++;
        if (bad_byte - bb0 !== 0) begin
            miscompares++;
            $display("FAIL good_byte_val: got %0d bad expected 0", bad_byte - bb0);
        end
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL good_done: got %0d pulses expected 1", done_cnt - d0);
        end
        vectors++;
        if ({CRC_OK, CRC_ERR, END_ERR, BUSY} !== 4'b1000) begin
            miscompares++;
            $display("FAIL good_flags: got %b expected 1000", {CRC_OK, CRC_ERR, END_ERR, BUSY});
        end
        vectors++;
        if (CRC_CALC !== 16'h7FA1) begin
            miscompares++;
            $display("FAIL good_crc_calc: got %h expected 7fa1", CRC_CALC);
        end
    endtask

    task automatic test_bad_crc();
        int d0;
        d0 = done_cnt;
        arm_pulse(1'b0, 1'b1);
        vectors++;
        if ({CRC_OK, CRC_CALC} !== 17'h0) begin
            miscompares++;
            $display("FAIL arm_clear: got ok=%b crc=%h expected ok=0 crc=0000", CRC_OK, CRC_CALC);
        end
        send_block(16'h7FA0, 1'b1, -1);
        repeat (2) tick();
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL badcrc_done: got %0d pulses expected 1", done_cnt - d0);
        end
        vectors++;
        if ({CRC_OK, CRC_ERR, END_ERR} !== 3'b010) begin
            miscompares++;
            $display("FAIL badcrc_flags: got %b expected 010", {CRC_OK, CRC_ERR, END_ERR});
        end
        vectors++;
        if (CRC_CALC !== 16'h7FA1) begin
            miscompares++;
            $display("FAIL badcrc_calc: got %h expected 7fa1", CRC_CALC);
        end
    endtask

    task automatic test_bad_end();
        arm_pulse(1'b0, 1'b1);
        vectors++;
        if (CRC_ERR !== 1'b0) begin
            miscompares++;
            $display("FAIL arm_clear_err: got %b expected 0", CRC_ERR);
        end
        send_block(16'h7FA1, 1'b0, -1);
        repeat (2) tick();
        vectors++;
        if ({CRC_OK, CRC_ERR, END_ERR} !== 3'b001) begin
            miscompares++;
            $display("FAIL badend_flags: got %b expected 001", {CRC_OK, CRC_ERR, END_ERR});
        end
    endtask

    task automatic test_en_gaps();
        int b0, bb0, d0;
        b0 = byte_cnt; bb0 = bad_byte; d0 = done_cnt;
        gap_max = 3;
        arm_mid = 1'b1;
        arm_pulse(1'b0, 1'b1);
        send_block(16'h7FA1, 1'b1, -1);
        gap_max = 0;
        arm_mid = 1'b0;
        repeat (4) tick();
        vectors++;
        if (byte_cnt - b0 !== 512 || bad_byte - bb0 !== 0) begin
            miscompares++;
            $display("FAIL gaps_bytes: got %0d (%0d bad) expected 512 (0 bad)", byte_cnt - b0, bad_byte - bb0);
        end
        vectors++;
        if (done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL gaps_done: got %0d pulses expected 1", done_cnt - d0);
        end
        vectors++;
        if ({CRC_OK, CRC_ERR, END_ERR, BUSY, CRC_CALC} !== {4'b1000, 16'h7FA1}) begin
            miscompares++;
            $display("FAIL gaps_result: got ok/err/end/busy=%b crc=%h expected 1000 7fa1", {CRC_OK, CRC_ERR, END_ERR, BUSY}, CRC_CALC);
        end
    endtask

    task automatic test_reset_abort();
        int b0, d0;
        b0 = byte_cnt; d0 = done_cnt;
        arm_pulse(1'b0, 1'b1);
        send_block(16'h7FA1, 1'b1, 100);
        tick();
        vectors++;
        if (byte_cnt - b0 !== 100) begin
            miscompares++;
            $display("FAIL abort_bytes: got %0d expected 100", byte_cnt - b0);
        end
        #2 RST = 1'b1;
        #1;
        vectors++;
        if ({BUSY, BYTE_VLD, DONE, CRC_OK, BYTE_OUT, CRC_CALC} !== 28'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got busy=%b out=%h crc=%h expected 0 00 0000", BUSY, BYTE_OUT, CRC_CALC);
        end
        repeat (3) tick();
        RST = 1'b0;
        repeat (3) tick();
        vectors++;
        if (done_cnt - d0 !== 0) begin
            miscompares++;
            $display("FAIL abort_done: got %0d pulses expected 0", done_cnt - d0);
        end
        arm_pulse(1'b0, 1'b1);
        send_block(16'h7FA1, 1'b1, -1);
        repeat (2) tick();
        vectors++;
        if ({CRC_OK, CRC_CALC, done_cnt - d0} !== {1'b1, 16'h7FA1, 32'd1}) begin
            miscompares++;
            $display("FAIL abort_rerun: got ok=%b crc=%h done=%0d expected ok=1 crc=7fa1 done=1", CRC_OK, CRC_CALC, done_cnt - d0);
        end
    endtask

`ifdef SD_RX_TIMEOUT_EN
    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        arm_pulse(1'b0, 1'b1);
        repeat (99) send_bit(1'b1);
        vectors++;
        if (BUSY !== 1'b1 || done_cnt - d0 !== 0) begin
            miscompares++;
            $display("FAIL to_early: got busy=%b done=%0d expected busy=1 done=0", BUSY, done_cnt - d0);
        end
        send_bit(1'b1);
        vectors++;
        if ({DONE, TO_ERR, BUSY, CRC_OK} !== 4'b1100) begin
            miscompares++;
            $display("FAIL to_fire: got done/to/busy/ok=%b expected 1100", {DONE, TO_ERR, BUSY, CRC_OK});
        end
    endtask
`else
    task automatic test_timeout();
        int d0;
        d0 = done_cnt;
        arm_pulse(1'b0, 1'b1);
        repeat (300) send_bit(1'b1);
        vectors++;
        if ({BUSY, TO_ERR} !== 2'b10 || done_cnt - d0 !== 0) begin
            miscompares++;
            $display("FAIL no_timeout: got busy/to=%b done=%0d expected 10 done=0", {BUSY, TO_ERR}, done_cnt - d0);
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_good_block();
        test_bad_crc();
        test_bad_end();
        test_en_gaps();
        test_reset_abort();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sd_dat_rx_crc_chk.md
Name: sd_dat_rx_crc_chk

Overview:
- Receive-side counterpart to the team's SD CRC16 generator.
- Captures one SD data block from a single DAT line (1-bit bus mode), delivers the data as bytes, and recomputes CRC16 (CCITT, x^16+x^12+x^5+1) over the data.
- Compares the result against the 16 CRC bits that follow the data, and checks the end bit.
- Sits between the SD pad sampling logic and the read-data buffer in the SD host controller.

Parameters:
- BLK_BYTES, 512, data bytes per block (1..4096).
- TO_CYCLES, 65535, EN-qualified samples allowed while waiting for the start bit (used only with the optional feature).

Ports:
- CLK  in  1  system clock.
- RST  in  1  reset.
- EN  in  1  sample strobe, one CLK pulse per SD clock rising edge; all protocol activity is gated by EN.
- ARM  in  1  one-cycle request to start waiting for a block.
- DAT_IN  in  1  DAT0 line, already synchronised.
- BYTE_OUT  out  8  received data byte, MSB first on the line.
- BYTE_VLD  out  1  one-cycle strobe, BYTE_OUT valid.
- BUSY  out  1  high from ARM accept until DONE.
- DONE  out  1  one-cycle pulse, block finished (normally or on timeout).
- CRC_OK  out  1  CRC matched and end bit good; valid from DONE until next ARM accept.
- CRC_ERR  out  1  received CRC differs from the calculated CRC.
- END_ERR  out  1  end bit sampled as 0.
- TO_ERR  out  1  start-bit timeout (feature only; tied 0 otherwise).
- CRC_CALC  out  16  calculated CRC, held after DONE for debug.

Behaviour:
- Reset: RST is asynchronous and active-high; the clock is CLK.
  - Reset values: all outputs 0, state IDLE, counters 0, CRC register 0.
  - RST mid-block aborts immediately; no DONE is issued.
- CRC LFSR: init 0 at ARM accept; updated on each EN-qualified data bit only.
  - inv = DAT_IN ^ crc[15].
  - Shift left; crc[0] = inv; crc[5] ^= inv; crc[12] ^= inv.
  - Start, CRC and end bits are excluded.
- State machine (transitions only on EN=1 cycles unless noted):
  - IDLE: on ARM=1 (EN not required), clear flags, clear CRC, go to WAIT_START, BUSY=1. A sample coinciding with the ARM cycle is ignored.
  - WAIT_START: DAT_IN=0 goes to DATA with the bit counter cleared. DAT_IN=1 stays.
  - DATA: shift DAT_IN into the byte register and the CRC. After BLK_BYTES*8 bits, go to CRC.
  - CRC: shift 16 bits MSB first into the rx_crc register. After the 16th bit, go to END.
  - END: sample the end bit and go to IDLE.
    - Next CLK: DONE=1, BUSY=0.
    - CRC_ERR = (rx_crc != crc).
    - END_ERR = ~DAT_IN.
    - CRC_OK = ~CRC_ERR & ~END_ERR.
- BYTE_VLD pulses one CLK after the EN cycle that sampled the 8th bit of each byte. BYTE_OUT holds until the next byte completes.
- Bit counter width is $clog2(BLK_BYTES*8)+1; no wrap within a block.
- ARM while BUSY is ignored. EN gaps of any length are tolerated; state holds.
- Flags are sticky until the next accepted ARM.

Optional Feature:
- Macro SD_RX_TIMEOUT_EN.
- Defined:
  - A counter increments on each EN cycle in WAIT_START.
  - On reaching TO_CYCLES, go to IDLE and pulse DONE with TO_ERR=1, CRC_OK=0.
  - The counter clears on ARM accept.
- Undefined: no counter; WAIT_START waits indefinitely; TO_ERR is constant 0.

Test Plan:
1. ARM, 3 idle 1s, start 0, 512 bytes of 0xFF, CRC 0x7FA1, end 1 -> 512 BYTE_VLD all 0xFF; DONE; CRC_OK=1; CRC_CALC=0x7FA1.
2. Same block with received CRC 0x7FA0 -> DONE, CRC_ERR=1, CRC_OK=0, CRC_CALC=0x7FA1.
3. Same block, end bit 0 -> END_ERR=1, CRC_ERR=0, CRC_OK=0.
4. Block of 0xFF sent with EN asserted every 3rd CLK, random gaps, ARM pulsed again mid-block -> identical result to test 1; second ARM has no effect.
5. RST asserted after byte 100 -> outputs 0 immediately, no DONE. A fresh ARM plus full block then passes with CRC_OK=1.
6. (SD_RX_TIMEOUT_EN, TO_CYCLES=100) ARM, DAT_IN held 1 -> DONE after 100 EN samples, TO_ERR=1, BUSY=0.
